// File: rtl/apb_pkg.sv
// Shared types and constants for the byte-wide memory target behind the APB slave.
// Everything here is used by the target, its read pipe and the bus interface.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Data returned for reads that fall outside the populated array.
    localparam logic [DATA_W-1:0] RD_OOR_VAL = 8'hFF;

    typedef enum logic {
        INIT,
        READY
    } mem_state_e;

endpackage

// File: rtl/apb_mem_target_if.sv
// Memory-port bundle between the APB slave (master side) and the memory target (slave side).
interface apb_mem_target_if;
    import apb_pkg::*;

    logic              ce;
    logic              wren;
    logic              rden;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;
    logic              init_busy;

    modport master (
        output ce, wren, rden, addr, wdata,
        input  rdata, rvalid, err, init_busy
    );

    modport slave (
        input  ce, wren, rden, addr, wdata,
        output rdata, rvalid, err, init_busy
    );

endinterface

// File: rtl/apb_mem_target_rd_pipe.sv
// Fixed-latency read-return pipe: RD_LATENCY stages of {valid, data}; the last data
// stage only loads on a valid result, so rdata holds between reads.
module mem_rd_pipe
    import apb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [RD_LATENCY-1:0] valid_d;
    logic [RD_LATENCY-1:0] stage_valid_in;
    logic [DATA_W-1:0]     data_q         [RD_LATENCY];
    logic [DATA_W-1:0]     data_d         [RD_LATENCY];
    logic [DATA_W-1:0]     stage_data_in  [RD_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_valid_in[gi] = in_valid;
                assign stage_data_in[gi]  = in_data;
            end else begin : g_link
                assign stage_valid_in[gi] = valid_q[gi-1];
                assign stage_data_in[gi]  = data_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        valid_d = stage_valid_in;
        for (int i = 0; i < RD_LATENCY; i++) begin
            data_d[i] = stage_data_in[i];
        end
        // Output stage doubles as the held rdata register.
        if (!stage_valid_in[RD_LATENCY-1]) begin
            data_d[RD_LATENCY-1] = data_q[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rvalid = valid_q[RD_LATENCY-1];
    assign rdata  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/apb_mem_target.sv
// Byte-wide memory target: self-initialising array, strobe decode with error flagging,
// and a fixed-latency read return through mem_rd_pipe.
module apb_mem_target
    import apb_pkg::*;
#(
    parameter int unsigned       DEPTH      = 256,
    parameter int unsigned       RD_LATENCY = 2,
    parameter logic [DATA_W-1:0] INIT_VAL   = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    apb_mem_target_if.slave bus
);

    localparam int unsigned       IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] pipe_in_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic access;
    logic addr_oor;

    assign access   = bus.ce & (bus.wren | bus.rden);
    assign addr_oor = {1'b0, bus.addr} >= DEPTH_W;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        rd_oor_d   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q[IDX_W-1:0];
        mem_wdata  = INIT_VAL;

        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                err_d  = access;
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (bus.ce) begin
                    if (bus.wren && bus.rden) begin
                        err_d = 1'b1;
                    end else if (bus.wren) begin
                        err_d     = addr_oor;
                        mem_we    = !addr_oor;
                        mem_waddr = bus.addr[IDX_W-1:0];
                        mem_wdata = bus.wdata;
                    end else if (bus.rden) begin
                        // Out-of-range reads still return a result, substituted after the array.
                        err_d      = addr_oor;
                        rd_valid_d = 1'b1;
                        rd_oor_d   = addr_oor;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    // Array with registered read; a read and a write never share an edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_valid_d) begin
            rd_data_q <= mem[bus.addr[IDX_W-1:0]];
        end
    end

    assign pipe_in_data = rd_oor_q ? RD_OOR_VAL : rd_data_q;

    mem_rd_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_valid(rd_valid_q),
        .in_data (pipe_in_data),
        .rvalid  (bus.rvalid),
        .rdata   (bus.rdata)
    );

    assign bus.err       = err_q;
    assign bus.init_busy = (state_q == INIT);

endmodule

// File: tb/tb_apb_mem_target.sv
// Scoreboard bench for apb_mem_target: a 256-byte and a 128-byte instance, both with 2-cycle reads.
module tb_apb_mem_target;

    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int         id;
        bit         is_rd;
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_rd [2];

    apb_mem_target_if bus ();
    apb_mem_target_if bus_s ();

    apb_mem_target #(.DEPTH(256), .RD_LATENCY(LAT), .INIT_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    apb_mem_target #(.DEPTH(128), .RD_LATENCY(LAT), .INIT_VAL(8'h00)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic rv, input logic [7:0] rd, input logic er);
        logic       exp_rv = 1'b0;
        logic       exp_er = 1'b0;
        logic [7:0] exp_d  = 8'h00;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].id == id && exp_q[i].due == cyc) begin
                if (exp_q[i].is_rd) begin
                    exp_rv = 1'b1;
                    exp_d  = exp_q[i].data;
                end else begin
                    exp_er = 1'b1;
                end
                exp_q.delete(i);
            end
        end
        if (reset) last_rd[id] = 8'h00;
        n_cmp++;
        if (rv !== exp_rv) begin
            n_err++;
            $display("FAIL rvalid[%0d] cyc %0d: got %b expected %b", id, cyc, rv, exp_rv);
        end
        if (exp_rv) last_rd[id] = exp_d;
        n_cmp++;
        if (rd !== last_rd[id]) begin
            n_err++;
            $display("FAIL rdata[%0d] cyc %0d: got %h expected %h", id, cyc, rd, last_rd[id]);
        end
        n_cmp++;
        if (er !== exp_er) begin
            n_err++;
            $display("FAIL err[%0d] cyc %0d: got %b expected %b", id, cyc, er, exp_er);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus.rvalid, bus.rdata, bus.err);
        mon(1, bus_s.rvalid, bus_s.rdata, bus_s.err);
    end

    task automatic clear_bus();
        bus.ce = 0;   bus.wren = 0;   bus.rden = 0;   bus.addr = 0;   bus.wdata = 0;
        bus_s.ce = 0; bus_s.wren = 0; bus_s.rden = 0; bus_s.addr = 0; bus_s.wdata = 0;
    endtask

    // One access, sampled at the next posedge; expectations are queued for the monitor.
    task automatic acc(input int id, input logic c, input logic w, input logic r,
                       input logic [7:0] a, input logic [7:0] d,
                       input bit e_err, input bit e_rd, input logic [7:0] e_data);
        int s;
        @(posedge clk);
        #1;
        clear_bus();
        if (id == 0) begin
            bus.ce = c;   bus.wren = w;   bus.rden = r;   bus.addr = a;   bus.wdata = d;
        end else begin
            bus_s.ce = c; bus_s.wren = w; bus_s.rden = r; bus_s.addr = a; bus_s.wdata = d;
        end
        s = cyc + 1;
        if (e_err) exp_q.push_back('{id, 1'b0, s, 8'h00});
        if (e_rd)  exp_q.push_back('{id, 1'b1, s + LAT, e_data});
    endtask

    task automatic rd(input int id, input logic [7:0] a, input logic [7:0] e);
        acc(id, 1, 0, 1, a, 8'h00, 0, 1, e);
    endtask

    task automatic wr(input int id, input logic [7:0] a, input logic [7:0] d);
        acc(id, 1, 1, 0, a, d, 0, 0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clear_bus();
        end
    endtask

    // Counts posedges after reset release until init_busy drops on each instance.
    task automatic count_init();
        int n = 0, n0 = 0, n1 = 0;
        while ((n0 == 0 || n1 == 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n0 == 0 && !bus.init_busy)   n0 = n;
            if (n1 == 0 && !bus_s.init_busy) n1 = n;
        end
        chk("init_edges_256", 16'(n0), 16'd256);
        chk("init_edges_128", 16'(n1), 16'd128);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        clear_bus();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdata", 16'(bus.rdata), 16'h00);
        chk("rst_rvalid", 16'(bus.rvalid), 16'h0);
        chk("rst_err", 16'(bus.err), 16'h0);
        chk("rst_init_busy", 16'(bus.init_busy), 16'h1);
        reset = 1'b0;
        count_init();

        rd(0, 8'h10, 8'h00);
        wr(0, 8'h03, 8'hA5);
        rd(0, 8'h03, 8'hA5);
        rd(0, 8'h00, 8'h00);
        rd(0, 8'h01, 8'h00);
        rd(0, 8'h02, 8'h00);
        rd(0, 8'h03, 8'hA5);
        rd(0, 8'h20, 8'h00);
        wr(0, 8'h20, 8'h5A);
        rd(0, 8'h20, 8'h5A);
        acc(0, 1, 1, 1, 8'h04, 8'hFF, 1, 0, 8'h00);
        rd(0, 8'h04, 8'h00);
        acc(0, 0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00);
        rd(0, 8'h03, 8'hA5);
        rd(0, 8'hFF, 8'h00);

        acc(1, 1, 0, 1, 8'h90, 8'h00, 1, 1, 8'hFF);
        acc(1, 1, 1, 0, 8'h90, 8'h77, 1, 0, 8'h00);
        acc(1, 1, 1, 0, 8'h80, 8'h77, 1, 0, 8'h00);
        rd(1, 8'h10, 8'h00);
        wr(1, 8'h7F, 8'h3C);
        rd(1, 8'h7F, 8'h3C);
        idle(4);

        // Two reads in flight when reset hits: neither may return.
        acc(0, 1, 0, 1, 8'h03, 8'h00, 0, 0, 8'h00);
        acc(0, 1, 0, 1, 8'h20, 8'h00, 0, 0, 8'h00);
        @(posedge clk);
        #2;
        reset = 1'b1;
        clear_bus();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("busy_mid_sweep", 16'(bus.init_busy), 16'h1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        count_init();

        rd(0, 8'h03, 8'h00);
        rd(0, 8'h20, 8'h00);
        rd(1, 8'h7F, 8'h00);
        idle(6);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_mem_target.md
# apb_mem_target

Byte-wide memory target at the far end of the Memory_Bus, answering the read/write strobes that the APB slave issues. It holds DEPTH bytes and returns read data through a fixed-latency pipeline with a valid strobe. It self-initialises its contents after reset and flags illegal strobe combinations. It is the memory side of the existing APB slave's memory port.

## Interface
- DEPTH, 256: number of bytes; legal 2..256; addresses ≥ DEPTH are out of range.
- RD_LATENCY, 2: cycles from read sample edge to rdata valid; legal 1..4.
- INIT_VAL, 8'h00: value written to every location by the post-reset init sweep.
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- ce  input  1  chip enable; wren/rden are ignored while low.
- wren  input  1  write strobe.
- rden  input  1  read strobe.
- addr  input  8  byte address.
- wdata  input  8  write data.
- rdata  output  8  read data; holds last returned value between reads.
- rvalid  output  1  one-cycle pulse, rdata carries a new read result.
- err  output  1  one-cycle pulse, illegal access seen on the previous edge.
- init_busy  output  1  high while the init sweep runs; accesses are rejected.

## Operation
- States: INIT, READY. Reset forces INIT with the sweep counter at 0.
- INIT: each posedge writes INIT_VAL to mem[cnt] and increments cnt. The edge that writes DEPTH-1 moves to READY. Any ce&(wren|rden) seen in INIT is dropped and flags err.
- READY, sampled on each posedge:
  - ce low: no action.
  - ce&wren&!rden, addr<DEPTH: mem[addr] ← wdata.
  - ce&rden&!wren: array read at this edge. Data = mem[addr], or 8'hFF if addr ≥ DEPTH. Data enters the read pipe.
  - ce&wren&rden: no write, no read, err.
  - Any access with addr ≥ DEPTH: err. A write is discarded. A read still returns 8'hFF with rvalid.
- Read pipe: RD_LATENCY stages of {valid, data}. It accepts one read per cycle, back-to-back, with no stall.
- A read returns the contents as of its sample edge. A write on a later edge does not alter an in-flight read. A write on an earlier edge is visible to the read.
- rdata updates only when the pipe output is valid. Otherwise it holds.

## Timing
- Reset values: rdata=8'h00, rvalid=0, err=0, init_busy=1, pipe valid bits=0. Memory contents are not reset; the sweep initialises them.
- Reset asserted mid-read drops every in-flight read, with no rvalid. Reset asserted mid-sweep restarts the sweep from address 0.
- Init duration: DEPTH posedges after reset deassertion. init_busy falls at the edge that writes DEPTH-1. The first accepted access is on the next edge.
- Read sampled at edge N gives rvalid=1 and rdata after edge N+RD_LATENCY, for exactly one cycle per read.
- Write sampled at edge N is readable by a read sampled at edge N+1.
- err is registered: an offending edge N gives err high after edge N, for one cycle. Consecutive offenses keep err high on consecutive cycles.
- Address width is 8 bits. There is no wrap: out-of-range addresses are errors, never aliased.

## Structure
- Shared package apb_pkg: ADDR_W=8, DATA_W=8, the memory-state enum {INIT, READY}, and constant RD_OOR_VAL=8'hFF.
- One sub-module, mem_rd_pipe: parameterised RD_LATENCY shift register of {valid, data} with async reset of the valid bits. It drives rvalid and rdata.
- The top holds the array, the init counter/FSM and the err logic.

## Test plan
- Reset, then count cycles → init_busy high for exactly 256 edges. Read addr 8'h10 → 8'h00 with rvalid two cycles after the sample edge.
- Write 8'hA5 to 8'h03, then read 8'h03 on the next edge → rdata=8'hA5 at sample+2. Then 4 back-to-back reads of 8'h00..8'h03 → 4 consecutive rvalid pulses in order.
- Read 8'h20, then write 8'h5A to 8'h20 on the following edge → the in-flight read returns the old value (8'h00). A second read returns 8'h5A.
- ce&wren&rden on addr 8'h04 with wdata=8'hFF → err pulse one cycle later, no rvalid, and mem[4] unchanged on a later read.
- With DEPTH=128: read 8'h90 → rdata=8'hFF with rvalid, plus an err pulse. Write 8'h90 → err, and mem[8'h10] is unchanged (no aliasing).
- Assert reset with 2 reads in flight and again mid-sweep at cnt=50 → no rvalid. init_busy then stays high for a full 256 edges after release.
